// File: rtl/posit_mult_arbiter.sv
// Shares one posit<16,1> multiplier between N_REQ stream requesters.
// Round-robin arbitration, grant locked for a whole window (until eow),
// with an in-order tag FIFO that routes each result back to its issuer.
module posit_mult_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_rts_i,
    output logic [N_REQ-1:0]              req_rtr_o,
    input  logic [N_REQ-1:0]              req_sow_i,
    input  logic [N_REQ-1:0]              req_eow_i,
    input  logic [N_REQ*21-1:0]           req_op1_i,
    input  logic [N_REQ*21-1:0]           req_op2_i,
    output logic                          mul_rts_o,
    input  logic                          mul_rtr_i,
    output logic                          mul_sow_o,
    output logic                          mul_eow_o,
    output logic [20:0]                   mul_op1_o,
    output logic [20:0]                   mul_op2_o,
    input  logic                          mul_rts_i,
    output logic                          mul_rtr_o,
    input  logic                          mul_sow_i,
    input  logic                          mul_eow_i,
    input  logic [35:0]                   mul_res_i,
    output logic [N_REQ-1:0]              res_rts_o,
    input  logic [N_REQ-1:0]              res_rtr_i,
    output logic                          res_sow_o,
    output logic                          res_eow_o,
    output logic [35:0]                   res_o,
    output logic [$clog2(TAG_DEPTH):0]    inflight_o,
    output logic                          err_o
);

    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] grant_q, grant_d;
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] tag_mem_q [TAG_DEPTH];
    logic [TW-1:0] tag_mem_d [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          found;
    logic [TW-1:0] winner;
    logic          full, empty;
    logic          issue, pop;
    logic [TW-1:0] tag;

    assign full  = (count_q == CW'(TAG_DEPTH));
    assign empty = (count_q == '0);
    assign tag   = tag_mem_q[rd_ptr_q];

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_rts_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
                found  = 1'b1;
                winner = TW'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
    end

    // Window FSM: IDLE spends one cycle arbitrating, BUSY forwards the
    // granted requester until its eow beat is accepted.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_rtr_o = '0;
        mul_rts_o = 1'b0;
        mul_sow_o = 1'b0;
        mul_eow_o = 1'b0;
        mul_op1_o = '0;
        mul_op2_o = '0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = winner;
                    rr_ptr_d = TW'((int'(winner) + 1) % N_REQ);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Stall while full even if a pop lands this cycle: keeps the
                // issue path free of any dependency on the return path.
                mul_rts_o          = req_rts_i[grant_q] & ~full;
                req_rtr_o[grant_q] = mul_rtr_i & ~full;
                mul_sow_o          = req_sow_i[grant_q];
                mul_eow_o          = req_eow_i[grant_q];
                mul_op1_o          = req_op1_i[int'(grant_q)*21 +: 21];
                mul_op2_o          = req_op2_i[int'(grant_q)*21 +: 21];
                issue              = mul_rts_o & mul_rtr_i;
                if (issue && req_eow_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return path: route by FIFO head; a result with no tag is drained and flagged.
    always_comb begin
        res_rts_o = '0;
        mul_rtr_o = 1'b0;
        pop       = 1'b0;
        err_d     = err_q;
        if (!empty) begin
            res_rts_o[tag] = mul_rts_i;
            mul_rtr_o      = res_rtr_i[tag];
            pop            = mul_rts_i & res_rtr_i[tag];
        end else begin
            mul_rtr_o = mul_rts_i;
            err_d     = err_q | mul_rts_i;
        end
    end

    assign res_o      = mul_res_i;
    assign res_sow_o  = mul_sow_i;
    assign res_eow_o  = mul_eow_i;
    assign inflight_o = count_q;
    assign err_o      = err_q;

    // Tag FIFO next-state: push the granted index on issue, pop on result transfer.
    always_comb begin
        tag_mem_d = tag_mem_q;
        if (issue) begin
            tag_mem_d[wr_ptr_q] = grant_q;
        end
        wr_ptr_d = wr_ptr_q + PW'(issue);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(issue) - CW'(pop);
    end

    // State registers; reset drops any open window and all outstanding tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
        end
    end

endmodule
